// File: rtl/avm_master_if.sv
// Bundle of the command, response and Avalon-MM master signals of avm_master.
// The master modport is the avm_master side; the slave modport is whatever drives and consumes it.
interface avm_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;

    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_read;
    logic              avm_m0_write;
    logic [DATA_W-1:0] avm_m0_writedata;
    logic [DATA_W-1:0] avm_m0_readdata;
    logic              avm_m0_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  rsp_ready,
        input  avm_m0_readdata, avm_m0_waitrequest,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output rsp_ready,
        output avm_m0_readdata, avm_m0_waitrequest,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata
    );
endinterface

// File: rtl/avm_master.sv
// Single-outstanding Avalon-MM master: one command in, one Avalon read/write, one response out.
// Optional waitrequest timeout abort is enabled by defining AVM_MASTER_TIMEOUT_EN.
module avm_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    avm_master_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("avm_master: TIMEOUT must be in 1..65535");
    end

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic              cmd_ready_reg;
    logic [ADDR_W-1:0] address_reg;
    logic [DATA_W-1:0] writedata_reg;
    logic              read_reg;
    logic              write_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_readdata_reg;

    logic accept;
    logic complete;
    logic abort;
    logic consume;

    // cmd_ready_reg is only high in IDLE outside reset, so it doubles as the accept qualifier
    assign accept   = cmd_ready_reg & bus.cmd_valid;
    assign complete = (state_reg == ST_BUSY) & ~bus.avm_m0_waitrequest;
    assign consume  = (state_reg == ST_RESP) & bus.rsp_ready;

`ifdef AVM_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    logic [15:0] stall_cnt_reg;
    logic        rsp_error_reg;

    // A drop of waitrequest on the limit edge takes the complete branch, not abort
    assign abort = (state_reg == ST_BUSY) & bus.avm_m0_waitrequest & (stall_cnt_reg == TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            if (accept) begin
                stall_cnt_reg <= '0;
            end else if ((state_reg == ST_BUSY) && bus.avm_m0_waitrequest) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end

            if (complete) begin
                rsp_error_reg <= 1'b0;
            end else if (abort) begin
                rsp_error_reg <= 1'b1;
            end else if (consume) begin
                rsp_error_reg <= 1'b0;
            end
        end
    end

    assign bus.rsp_error = rsp_error_reg;
`else
    assign abort         = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)             state_next = ST_BUSY;
            ST_BUSY: if (complete || abort)  state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready)      state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            cmd_ready_reg    <= 1'b0;
            address_reg      <= '0;
            writedata_reg    <= '0;
            read_reg         <= 1'b0;
            write_reg        <= 1'b0;
            rsp_valid_reg    <= 1'b0;
            rsp_readdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == ST_IDLE);

            if (accept) begin
                address_reg   <= bus.cmd_address;
                writedata_reg <= bus.cmd_writedata;
                read_reg      <= ~bus.cmd_write;
                write_reg     <= bus.cmd_write;
            end else if (complete || abort) begin
                read_reg  <= 1'b0;
                write_reg <= 1'b0;
            end

            if (complete) begin
                rsp_valid_reg    <= 1'b1;
                rsp_readdata_reg <= read_reg ? bus.avm_m0_readdata : '0;
            end else if (abort) begin
                rsp_valid_reg    <= 1'b1;
                rsp_readdata_reg <= '0;
            end else if (consume) begin
                rsp_valid_reg    <= 1'b0;
                rsp_readdata_reg <= '0;
            end
        end
    end

    assign bus.cmd_ready        = cmd_ready_reg;
    assign bus.avm_m0_address   = address_reg;
    assign bus.avm_m0_writedata = writedata_reg;
    assign bus.avm_m0_read      = read_reg;
    assign bus.avm_m0_write     = write_reg;
    assign bus.rsp_valid        = rsp_valid_reg;
    assign bus.rsp_readdata     = rsp_readdata_reg;
endmodule

// File: tb/tb_avm_master.sv
// Bench for avm_master: transaction-level model checked every cycle plus directed literal checks.
// Builds with or without AVM_MASTER_TIMEOUT_EN; the timeout scenario adapts to the build.
`timescale 1ns/1ps
module tb_avm_master;
    localparam int     ADDR_W    = 4;
    localparam int     DATA_W    = 32;
    localparam int     TB_TO     = 8;
    localparam longint STUCK     = 64'd1_000_000;
    localparam logic [DATA_W-1:0] IDLE_DATA = 32'hA5A5_5A5A;
`ifdef AVM_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    avm_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avm_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TB_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Slave behaviour of the command being presented, captured by the model on acceptance
    longint            drv_stall = 0;
    logic [DATA_W-1:0] drv_rdata = '0;

    // Model of the one outstanding transaction
    bit                m_have     = 1'b0;
    bit                m_rst_prev = 1'b1;
    bit                m_wr       = 1'b0;
    bit                m_err      = 1'b0;
    logic [ADDR_W-1:0] m_addr     = '0;
    logic [DATA_W-1:0] m_wdata    = '0;
    logic [DATA_W-1:0] m_rdata    = '0;
    logic [DATA_W-1:0] m_exp      = '0;
    longint            m_S        = 0;
    longint            m_acc      = 0;
    longint            m_done     = 0;
    int                m_n        = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (m_rst_prev) begin
                chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
                chk("rst_read", 64'(bus.avm_m0_read), 64'd0);
                chk("rst_write", 64'(bus.avm_m0_write), 64'd0);
                chk("rst_address", 64'(bus.avm_m0_address), 64'd0);
                chk("rst_writedata", 64'(bus.avm_m0_writedata), 64'd0);
                chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("rst_rsp_readdata", 64'(bus.rsp_readdata), 64'd0);
                chk("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
            end else if (!m_have) begin
                chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
                chk("idle_read", 64'(bus.avm_m0_read), 64'd0);
                chk("idle_write", 64'(bus.avm_m0_write), 64'd0);
                chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("idle_rsp_readdata", 64'(bus.rsp_readdata), 64'd0);
                chk("idle_rsp_error", 64'(bus.rsp_error), 64'd0);
            end else if (cyc <= m_done) begin
                chk("busy_cmd_ready", 64'(bus.cmd_ready), 64'd0);
                chk("busy_read", 64'(bus.avm_m0_read), 64'(!m_wr));
                chk("busy_write", 64'(bus.avm_m0_write), 64'(m_wr));
                chk("busy_address", 64'(bus.avm_m0_address), 64'(m_addr));
                if (m_wr) chk("busy_writedata", 64'(bus.avm_m0_writedata), 64'(m_wdata));
                chk("busy_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("busy_rsp_readdata", 64'(bus.rsp_readdata), 64'd0);
            end else begin
                chk("resp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
                chk("resp_read", 64'(bus.avm_m0_read), 64'd0);
                chk("resp_write", 64'(bus.avm_m0_write), 64'd0);
                chk("resp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
                chk("resp_rsp_readdata", 64'(bus.rsp_readdata), 64'(m_exp));
                chk("resp_rsp_error", 64'(bus.rsp_error), 64'(m_err));
            end
            chk("rd_wr_exclusive", 64'(bus.avm_m0_read & bus.avm_m0_write), 64'd0);

            // Advance the model to the next cycle from the inputs seen by the coming edge
            if (reset) begin
                m_rst_prev = 1'b1;
                m_have     = 1'b0;
            end else if (m_rst_prev) begin
                m_rst_prev = 1'b0;
            end else if (m_have) begin
                if (cyc > m_done && bus.rsp_ready) begin
                    $display("txn %0d %s addr=0x%0h wdata=0x%08h rdata=0x%08h err=%0b accepted=%0d responded=%0d",
                             m_n, m_wr ? "WR" : "RD", m_addr, m_wdata, m_exp, m_err, m_acc, m_done + 1);
                    m_n++;
                    m_have = 1'b0;
                end
            end else if (bus.cmd_valid) begin
                m_have  = 1'b1;
                m_acc   = cyc;
                m_wr    = bus.cmd_write;
                m_addr  = bus.cmd_address;
                m_wdata = bus.cmd_writedata;
                m_S     = drv_stall;
                m_rdata = drv_rdata;
                m_err   = TO_EN && (m_S > TB_TO);
                m_done  = cyc + 1 + (m_err ? longint'(TB_TO) : m_S);
                m_exp   = (m_err || m_wr) ? '0 : m_rdata;
            end
        end
    end

    // Avalon slave: stalls the first m_S strobe cycles of each transfer
    bit     s_active = 1'b0;
    longint s_cnt    = 0;
    initial begin
        bus.avm_m0_waitrequest = 1'b0;
        bus.avm_m0_readdata    = IDLE_DATA;
        forever begin
            @(posedge clk);
            #1;
            if (bus.avm_m0_read || bus.avm_m0_write) begin
                if (!s_active) begin
                    s_active = 1'b1;
                    s_cnt    = 0;
                end
                bus.avm_m0_waitrequest = (s_cnt < m_S);
                bus.avm_m0_readdata    = m_rdata;
                s_cnt++;
            end else begin
                s_active               = 1'b0;
                bus.avm_m0_waitrequest = 1'b0;
                bus.avm_m0_readdata    = IDLE_DATA;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input bit keep, output longint acc);
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
        tick();
        bus.cmd_valid = keep;
    endtask

    task automatic send(input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input longint stall, input logic [DATA_W-1:0] rd, input bit keep,
                        output longint acc);
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = w;
        bus.cmd_address   = a;
        bus.cmd_writedata = d;
        drv_stall         = stall;
        drv_rdata         = rd;
        wait_accept(keep, acc);
    endtask

    task automatic get_rsp(output longint rc, output logic [DATA_W-1:0] rdata, output logic err,
                           output int strobes);
        strobes = 0;
        rc      = -1;
        rdata   = '0;
        err     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rc    = cyc;
                rdata = bus.rsp_readdata;
                err   = bus.rsp_error;
                break;
            end
            if (bus.avm_m0_read || bus.avm_m0_write) strobes++;
        end
        if (rc < 0) chk("response_timeout", 64'd0, 64'd1);
        tick();
    endtask

    longint            acc, acc2, rc, m_cyc;
    longint            accs [4];
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                strobes;
    int                held;

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_address   = '0;
        bus.cmd_writedata = '0;
        bus.rsp_ready     = 1'b1;

        repeat (3) tick();
        @(negedge clk);
        chk("lit_reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("lit_post_reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();

        // Zero-wait write
        send(1'b1, 4'h3, 32'hDEAD_BEEF, 0, 32'h5555_AAAA, 1'b0, acc);
        get_rsp(rc, rdata, err, strobes);
        chk("lit_wr_latency", 64'(rc - acc), 64'd2);
        chk("lit_wr_strobe_cycles", 64'(strobes), 64'd1);
        chk("lit_wr_rdata", 64'(rdata), 64'd0);
        chk("lit_wr_error", 64'(err), 64'd0);

        // Read stalled 4 cycles
        send(1'b0, 4'hA, 32'h0, 4, 32'h1234_5678, 1'b0, acc);
        get_rsp(rc, rdata, err, strobes);
        chk("lit_rd_latency", 64'(rc - acc), 64'd6);
        chk("lit_rd_strobe_cycles", 64'(strobes), 64'd5);
        chk("lit_rd_rdata", 64'(rdata), 64'h1234_5678);

        // Response backpressure with a blocked command waiting
        bus.rsp_ready = 1'b0;
        send(1'b0, 4'h2, 32'h0, 1, 32'hCAFE_F00D, 1'b0, acc);
        bus.cmd_valid     = 1'b1;
        bus.cmd_write     = 1'b1;
        bus.cmd_address   = 4'h7;
        bus.cmd_writedata = 32'h7777_7777;
        drv_stall         = 0;
        drv_rdata         = 32'h1212_1212;
        get_rsp(rc, rdata, err, strobes);
        chk("lit_bp_latency", 64'(rc - acc), 64'd3);
        repeat (10) tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        m_cyc = cyc;
        chk("lit_bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("lit_bp_rsp_held", 64'(bus.rsp_readdata), 64'hCAFE_F00D);
        wait_accept(1'b0, acc2);
        chk("lit_bp_next_accept", 64'(acc2 - m_cyc), 64'd1);
        get_rsp(rc, rdata, err, strobes);
        chk("lit_bp_wr_rdata", 64'(rdata), 64'd0);

        // Back-to-back commands with cmd_valid held high
        send(1'b1, 4'h1, 32'h1111_1111, 0, 32'h0BAD_0001, 1'b1, accs[0]);
        send(1'b0, 4'h4, 32'h0,         0, 32'h4444_4444, 1'b1, accs[1]);
        send(1'b1, 4'hF, 32'hFFFF_0000, 0, 32'h0BAD_0003, 1'b1, accs[2]);
        send(1'b0, 4'h0, 32'h0,         0, 32'h0000_ABCD, 1'b0, accs[3]);
        get_rsp(rc, rdata, err, strobes);
        for (int k = 1; k < 4; k++) chk("lit_b2b_spacing", 64'(accs[k] - accs[k-1]), 64'd3);
        chk("lit_b2b_last_rdata", 64'(rdata), 64'h0000_ABCD);

        // Reset during a stalled read
        send(1'b0, 4'h9, 32'h0, STUCK, 32'h9999_9999, 1'b0, acc);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("lit_midrst_read", 64'(bus.avm_m0_read), 64'd0);
        chk("lit_midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("lit_midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        tick();

`ifdef AVM_MASTER_TIMEOUT_EN
        // Stuck waitrequest aborts after TIMEOUT+1 strobe cycles
        send(1'b0, 4'h5, 32'h0, STUCK, 32'h5A5A_0005, 1'b0, acc);
        get_rsp(rc, rdata, err, strobes);
        chk("lit_to_strobe_cycles", 64'(strobes), 64'd9);
        chk("lit_to_latency", 64'(rc - acc), 64'd10);
        chk("lit_to_error", 64'(err), 64'd1);
        chk("lit_to_rdata", 64'(rdata), 64'd0);
        // waitrequest drops on the limit edge: normal completion
        send(1'b0, 4'h6, 32'h0, TB_TO, 32'h0BAD_CAFE, 1'b0, acc);
        get_rsp(rc, rdata, err, strobes);
        chk("lit_to_edge_error", 64'(err), 64'd0);
        chk("lit_to_edge_rdata", 64'(rdata), 64'h0BAD_CAFE);
        chk("lit_to_edge_strobe_cycles", 64'(strobes), 64'd9);
`else
        // Without the timeout the master waits indefinitely
        send(1'b0, 4'h5, 32'h0, STUCK, 32'h5A5A_0005, 1'b0, acc);
        held = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.avm_m0_read && !bus.rsp_valid) held++;
        end
        chk("lit_noto_busy_cycles", 64'(held), 64'd1000);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
